// File: rtl/display_scan_mux.sv
// display_scan_mux: time-shared four-digit BCD scan with frame-aligned value updates
module display_scan_mux #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  input  logic [15:0] value_in,
  output logic        load_ready,
  output logic [3:0]  bcd_out,
  output logic [3:0]  enable,
  output logic        frame_swap
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK = PW'(BLANK_CYCLES);
  logic [PW-1:0] prescaler;
  logic [1:0]    digit_idx;
  logic [15:0]   active, shadow, upper;
  logic          pending, tick, boundary, blank;
  assign tick       = prescaler == LAST;
  assign boundary   = tick && digit_idx == 2'd3;
  assign load_ready = ~pending;
  // slot prescaler and digit rotation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      digit_idx <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) digit_idx <= digit_idx + 2'd1;
    end
  end
  // shadow capture on handshake, promotion to the displayed value at frame boundaries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active     <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      frame_swap <= 1'b0;
    end else begin
      frame_swap <= boundary && pending;
      if (load_valid && !pending) begin
        shadow  <= value_in;
        pending <= 1'b1;
      end else if (boundary && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end
    end
  end
  // current digit select and blanking (anti-ghost interval, invalid BCD, leading zeros)
  always_comb begin
    upper   = active >> {digit_idx, 2'b00};
    bcd_out = upper[3:0];
    blank   = prescaler < BLANK || upper[3:0] > 4'd9 || (LZ_BLANK && digit_idx != 2'd0 && upper == 16'h0);
    enable  = blank ? 4'hF : ~(4'b0001 << digit_idx);
  end
endmodule
